// File: rtl/muldiv_unit.sv
// Multi-cycle RV M-extension unit: radix-2^MUL_BITS shift-add multiplier and restoring divider.
// Operands are latched on acceptance and the result is held in DONE until the consumer takes it.
module muldiv_unit #(
    parameter int XLEN     = 32,
    parameter int MUL_BITS = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] result_o,
    output logic            dbz_o,
    output logic            busy_o
);
    localparam int N_MUL = XLEN / MUL_BITS;
    localparam int CW    = $clog2(XLEN);
    localparam int MW    = XLEN + MUL_BITS;
    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [2:0]          op_q, op_d;
    logic                sa_q, sa_d, sb_q, sb_d;
    logic [XLEN-1:0]     opnd_q, opnd_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [XLEN-1:0]     result_q, result_d;
    logic                dbz_q, dbz_d;

    logic                accept, is_div, b_zero, ovf, signed_a, signed_b;
    logic [XLEN-1:0]     mag_a, mag_b;
    logic [MW-1:0]       mul_sum;
    logic [XLEN:0]       div_shift, div_diff;
    logic                q_bit;
    logic [2*XLEN-1:0]   prod_s;
    logic [XLEN-1:0]     quot_s, rem_s;

    assign accept   = in_valid_i & (state_q == S_IDLE) & ~flush_i;
    assign is_div   = op_i[2];
    assign signed_a = (op_i == 3'd0) | (op_i == 3'd1) | (op_i == 3'd2) | (op_i == 3'd4) | (op_i == 3'd6);
    assign signed_b = (op_i == 3'd0) | (op_i == 3'd1) | (op_i == 3'd4) | (op_i == 3'd6);
    assign b_zero   = (b_i == '0);
    assign ovf      = ((op_i == 3'd4) | (op_i == 3'd6)) & (a_i == MIN_VAL) & (b_i == '1);
    assign mag_a    = (signed_a & a_i[XLEN-1]) ? -a_i : a_i;
    assign mag_b    = (signed_b & b_i[XLEN-1]) ? -b_i : b_i;

    // acc holds {partial high product, remaining multiplier} or {partial remainder, dividend/quotient}
    assign mul_sum   = MW'(acc_q[2*XLEN-1:XLEN]) + MW'(opnd_q) * MW'(acc_q[MUL_BITS-1:0]);
    assign div_shift = acc_q[2*XLEN-1:XLEN-1];
    assign div_diff  = div_shift - {1'b0, opnd_q};
    assign q_bit     = ~div_diff[XLEN];

    assign prod_s = (sa_q ^ sb_q) ? -acc_q : acc_q;
    assign quot_s = (sa_q ^ sb_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    assign rem_s  = sa_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (is_div && (b_zero || ovf)) state_d = S_DONE;
                    else if (is_div)               state_d = S_DIV;
                    else                           state_d = S_MUL;
                end
            end
            S_MUL:   if (cnt_q == '0) state_d = S_FIX;
            S_DIV:   if (cnt_q == '0) state_d = S_FIX;
            S_FIX:   state_d = S_DONE;
            S_DONE:  if (out_ready_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (flush_i) state_d = S_IDLE;
    end

    always_comb begin
        op_d     = op_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        dbz_d    = dbz_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d  = op_i;
                    sa_d  = signed_a & a_i[XLEN-1];
                    sb_d  = signed_b & b_i[XLEN-1];
                    dbz_d = is_div & b_zero;
                    if (is_div) begin
                        opnd_d = mag_b;
                        acc_d  = {{XLEN{1'b0}}, mag_a};
                        cnt_d  = CW'(XLEN - 1);
                        if (b_zero)   result_d = op_i[1] ? a_i : '1;
                        else if (ovf) result_d = op_i[1] ? '0 : MIN_VAL;
                    end else begin
                        opnd_d = mag_a;
                        acc_d  = {{XLEN{1'b0}}, mag_b};
                        cnt_d  = CW'(N_MUL - 1);
                    end
                end
            end
            S_MUL: begin
                acc_d = {mul_sum, acc_q[XLEN-1:MUL_BITS]};
                cnt_d = cnt_q - CW'(1);
            end
            S_DIV: begin
                acc_d = {(q_bit ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0]), acc_q[XLEN-2:0], q_bit};
                cnt_d = cnt_q - CW'(1);
            end
            S_FIX: begin
                case (op_q)
                    3'd0:       result_d = prod_s[XLEN-1:0];
                    3'd1, 3'd2,
                    3'd3:       result_d = prod_s[2*XLEN-1:XLEN];
                    3'd4, 3'd5: result_d = quot_s;
                    default:    result_d = rem_s;
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            op_q     <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            opnd_q   <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            dbz_q    <= 1'b0;
        end else begin
            op_q     <= op_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            dbz_q    <= dbz_d;
        end
    end

    always_comb begin
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        busy_o      = 1'b1;
        dbz_o       = 1'b0;
        case (state_q)
            S_IDLE: begin
                in_ready_o = 1'b1;
                busy_o     = 1'b0;
            end
            S_DONE: begin
                out_valid_o = 1'b1;
                dbz_o       = dbz_q;
            end
            default: ;
        endcase
    end

    assign result_o = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit (XLEN=32, MUL_BITS=4): fixed vectors, latency,
// backpressure, flush/reset recovery, plus a short randomised sweep against a behavioural model.
module tb_muldiv_unit;
    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            flush = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [2:0]      op = '0;
    logic [XLEN-1:0] a = '0;
    logic [XLEN-1:0] b = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [XLEN-1:0] result;
    logic            dbz;
    logic            busy;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(XLEN), .MUL_BITS(4)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .op_i(op), .a_i(a), .b_i(b),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .result_o(result), .dbz_o(dbz), .busy_o(busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Present a request before edge E0; return #1 after E0 with stale inputs scrambled.
    task automatic issue(input logic [2:0] o, input logic [XLEN-1:0] x, input logic [XLEN-1:0] y);
        @(negedge clk);
        op = o; a = x; b = y; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        op = 3'($urandom); a = $urandom; b = $urandom;
    endtask

    // Latency counts edges from E0 inclusive.
    task automatic wait_done(output int lat);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check("out_valid_seen", 64'(out_valid), 64'd1);
    endtask

    task automatic take(output logic [XLEN-1:0] r, output logic d);
        r = result; d = dbz;
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [2:0] o, input logic [XLEN-1:0] x,
                          input logic [XLEN-1:0] y, input logic [XLEN-1:0] exp_r,
                          input logic exp_d, input int exp_lat);
        int lat;
        logic [XLEN-1:0] r;
        logic d;
        issue(o, x, y);
        wait_done(lat);
        take(r, d);
        check({tag, "_res"}, 64'(r), 64'(exp_r));
        check({tag, "_dbz"}, 64'(d), 64'(exp_d));
        if (exp_lat > 0) check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    endtask

    function automatic logic [XLEN-1:0] ref_model(input logic [2:0] o, input logic [XLEN-1:0] x,
                                                  input logic [XLEN-1:0] y);
        logic signed [63:0] ps, psu;
        logic [63:0] pu;
        ps  = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
        psu = $signed({{32{x[31]}}, x}) * $signed({32'b0, y});
        pu  = {32'b0, x} * {32'b0, y};
        case (o)
            3'd0: return ps[31:0];
            3'd1: return ps[63:32];
            3'd2: return psu[63:32];
            3'd3: return pu[63:32];
            3'd4: return (y == 0) ? 32'hFFFF_FFFF :
                          (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) ? 32'h8000_0000 :
                          32'($signed(x) / $signed(y));
            3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
            3'd6: return (y == 0) ? x :
                          (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) ? 32'h0 :
                          32'($signed(x) % $signed(y));
            default: return (y == 0) ? x : x % y;
        endcase
    endfunction

    initial begin
        int lat;
        logic seen;
        logic [XLEN-1:0] r, x, y;
        logic [2:0] o;
        logic d;

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_dbz", 64'(dbz), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        @(negedge clk); rst = 1'b0;

        run_op("mulhu_ff", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 10);
        run_op("mul_ff",   3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 10);
        run_op("mulh_ff",  3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 10);
        run_op("mulhsu_ff",3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 10);
        run_op("mul_dec",  3'd0, 32'd12345, 32'd678, 32'h007F_B6F6, 1'b0, 10);
        run_op("mulh_min", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, 10);
        run_op("mul_neg",  3'd0, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, 1'b0, 10);
        run_op("mulh_neg", 3'd1, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 1'b0, 10);

        run_op("div_m7_2",  3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 34);
        run_op("rem_m7_2",  3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, 34);
        run_op("divu_100",  3'd5, 32'd100, 32'd7, 32'd14, 1'b0, 34);
        run_op("remu_100",  3'd7, 32'd100, 32'd7, 32'd2, 1'b0, 34);
        run_op("div_7_m2",  3'd4, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, 34);
        run_op("rem_7_m2",  3'd6, 32'd7, 32'hFFFF_FFFE, 32'd1, 1'b0, 34);
        run_op("remu_big",  3'd7, 32'hFFFF_FFFF, 32'h10, 32'hF, 1'b0, 34);

        run_op("div_dbz",  3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1, 1);
        run_op("divu_dbz", 3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1, 1);
        run_op("remu_dbz", 3'd7, 32'd5, 32'd0, 32'd5, 1'b1, 1);
        run_op("rem_dbz",  3'd6, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 1'b1, 1);
        run_op("div_ovf",  3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1);
        run_op("rem_ovf",  3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1'b0, 1);

        // Backpressure, then a pending request that must wait one cycle after release.
        issue(3'd5, 32'd100, 32'd7);
        wait_done(lat);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            check("hold_result", 64'(result), 64'd14);
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_in_ready", 64'(in_ready), 64'd0);
        end
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1; op = 3'd0; a = 32'd3; b = 32'd4;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("release_busy", 64'(busy), 64'd0);
        check("release_in_ready", 64'(in_ready), 64'd1);
        check("release_valid", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        in_valid = 1'b0; a = $urandom; b = $urandom;
        wait_done(lat);
        take(r, d);
        check("reaccept_res", 64'(r), 64'd12);
        check("reaccept_lat", 64'(lat), 64'd10);

        // Flush beats accept.
        @(negedge clk); in_valid = 1'b1; flush = 1'b1; op = 3'd5; a = 32'd9; b = 32'd3;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        check("flush_vs_accept_busy", 64'(busy), 64'd0);

        // Abort a MUL at iteration 5 by flush, then by reset; both must recover cleanly.
        for (int k = 0; k < 2; k++) begin
            issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
            repeat (4) @(posedge clk);
            @(negedge clk);
            if (k == 0) flush = 1'b1; else rst = 1'b1;
            @(posedge clk); #1;
            flush = 1'b0; rst = 1'b0;
            check(k == 0 ? "flush_busy" : "rst_mid_busy", 64'(busy), 64'd0);
            check(k == 0 ? "flush_in_ready" : "rst_mid_in_ready", 64'(in_ready), 64'd1);
            seen = 1'b0;
            repeat (15) begin
                @(posedge clk); #1;
                seen |= out_valid;
            end
            check(k == 0 ? "flush_no_valid" : "rst_no_valid", 64'(seen), 64'd0);
            run_op(k == 0 ? "post_flush_divu" : "post_rst_divu", 3'd5, 32'd9, 32'd3, 32'd3, 1'b0, 34);
        end

        // Randomised sweep with operands biased towards edge values.
        for (int i = 0; i < 120; i++) begin
            o = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 4))
                0: x = 32'h8000_0000;
                1: x = 32'hFFFF_FFFF;
                default: x = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0: y = 32'h0;
                1: y = 32'hFFFF_FFFF;
                2: y = 32'($urandom_range(1, 15));
                default: y = $urandom;
            endcase
            run_op("rand", o, x, y, ref_model(o, x, y), o[2] && (y == 0), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
